// File: rtl/edge_event_arbiter.sv
// Rising-edge event capture on N_CH level inputs, served round-robin onto one valid/ready port.
// Define EDGE_ARB_SYNC_EN to insert a 2-flop synchronizer on every d_in bit.
module edge_event_arbiter #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N_CH-1:0] d_in,
  input  logic [N_CH-1:0] ch_en,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [ID_W-1:0] evt_id,
  output logic [N_CH-1:0] ovf,
  input  logic            ovf_clr
);

  typedef enum logic {
    S_IDLE,
    S_OFFER
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [N_CH-1:0] d_s;
  logic [N_CH-1:0] d_q;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] pending_nxt;
  logic [N_CH-1:0] load_oh;
  logic [N_CH-1:0] ovf_set;
  logic [N_CH-1:0] ovf_nxt;
  logic [ID_W-1:0] last_id;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] idx;
  logic            any_pend;
  logic            found;
  logic            load;

`ifdef EDGE_ARB_SYNC_EN
  logic [N_CH-1:0] sync1;
  logic [N_CH-1:0] sync2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= d_in;
      sync2 <= sync1;
    end
  end

  assign d_s = sync2;
`else
  assign d_s = d_in;
`endif

  // ch_en masks detection only; d_q keeps tracking so re-enabling a high input is not an edge
  assign rise     = d_s & ~d_q & ch_en;
  assign any_pend = |pending;

  // Round-robin search starting just after the last served channel
  always_comb begin
    win_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned off = 1; off <= N_CH; off++) begin
      idx = ID_W'((32'(last_id) + off) % N_CH);
      if (!found && pending[idx]) begin
        found  = 1'b1;
        win_id = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_pend) begin
          load      = 1'b1;
          state_nxt = S_OFFER;
        end
      end
      S_OFFER: begin
        if (evt_ready) begin
          if (any_pend) load = 1'b1;
          else          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A rise on the channel being loaded re-arms pending without counting as an overflow
  always_comb begin
    load_oh = '0;
    if (load) load_oh[win_id] = 1'b1;
    pending_nxt = (pending & ~load_oh) | rise;
    ovf_set     = rise & pending & ~load_oh;
    ovf_nxt     = (ovf & {N_CH{~ovf_clr}}) | ovf_set;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      d_q     <= '0;
      pending <= '0;
      ovf     <= '0;
      evt_id  <= '0;
      last_id <= ID_W'(N_CH - 1);
    end else begin
      state   <= state_nxt;
      d_q     <= d_s;
      pending <= pending_nxt;
      ovf     <= ovf_nxt;
      if (load) begin
        evt_id  <= win_id;
        last_id <= win_id;
      end
    end
  end

  assign evt_valid = (state == S_OFFER);

endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Multi-channel rising-edge event controller that sits in front of the pulse-detect datapath. It samples `N_CH` level inputs and records a pending event per channel on each enabled rising edge. It then serializes the pending events, in round-robin order, onto a single valid/ready event port for a downstream consumer. Events that are lost are flagged per channel in a sticky overflow register.

## Interface
- `N_CH`, 4, number of input channels (2..16)
- `ID_W`, 2, width of channel ID; must equal clog2(`N_CH`)

- `clk`  in  1  system clock, all logic on rising edge
- `rstn`  in  1  asynchronous active-low reset
- `d_in`  in  N_CH  level inputs, one per channel
- `ch_en`  in  N_CH  per-channel detect enable
- `evt_valid`  out  1  event offered on `evt_id`
- `evt_ready`  in  1  consumer accepts event
- `evt_id`  out  ID_W  channel number of offered event
- `ovf`  out  N_CH  sticky per-channel overflow flags
- `ovf_clr`  in  1  synchronous clear of all `ovf` bits

## Operation
- Sample register `d_q[N_CH]` holds the previous sampled `d_in`, reset 0.
- `rise[i] = d_s[i] & ~d_q[i] & ch_en[i]`. `d_s` is `d_in` directly, or the synchronized value when the synchronizer is compiled in (see Configuration).
- `pending[i]`, reset 0:
  - Set on `rise[i]`.
  - Cleared when channel i is loaded into the output register.
  - If rise and load hit the same channel in the same cycle, pending stays 1 and no overflow is raised.
- Overflow: `rise[i]` while `pending[i]=1` and channel i is not loaded that cycle sets `ovf[i]`.
  - `ovf_clr` clears all bits.
  - A set in the same cycle as `ovf_clr` wins.
- `ch_en[i]=0` masks new detection only. Existing pending is still served, and `d_q` keeps tracking.
- Round-robin pointer `last_id`, reset `N_CH-1`, so channel 0 has first priority after reset.
  - Search order is `last_id+1`, `last_id+2`, … with wrap modulo `N_CH`.
  - `last_id` updates to the loaded ID on every load.
- FSM, 2 states:
  - IDLE (reset):
    - `evt_valid=0`.
    - If any pending, load the winner into `evt_id`, clear its pending, and go to OFFER.
  - OFFER:
    - `evt_valid=1`; `evt_id` held stable until handshake.
    - On `evt_valid & evt_ready`: if any pending (pending registered value, excluding same-cycle rises), load the next winner and stay in OFFER with no bubble. Otherwise go to IDLE.
- `evt_valid` never drops without a handshake.
- Reset mid-operation: all state returns to reset values immediately, and the offered event is discarded.

## Timing
- Reset values: `evt_valid=0`, `evt_id=0`, `ovf=0`, `pending=0`, `d_q=0`.
- An input already high when reset is released produces one event.
- Latency, synchronizer out, channel idle: `d_in` sampled high at edge k sets pending at k. It is loaded at k+1, so `evt_valid`/`evt_id` are visible after edge k+1.
- Throughput: one event per cycle while `evt_ready=1` and events are pending.
- A pulse on `d_in` shorter than one clock period may be missed (no requirement).

## Configuration
- `EDGE_ARB_SYNC_EN` defined: each `d_in` bit passes through a 2-flop synchronizer (reset 0) before edge detection.
  - `d_in` may be asynchronous.
  - Latency becomes k+3.
- Not defined: `d_in` feeds edge detection directly and must be synchronous to `clk`; latency is k+1.
- Ports and all other behaviour are identical in both builds.

## Test plan
Sync macro off, `N_CH=4`, all `ch_en=1`, `evt_ready=1` unless stated.
- Single edge: `d_in[2]` 0→1 at edge 10 → `evt_valid=1`, `evt_id=2` for exactly one cycle after edge 11; no further event while held high; a second 0→1 produces a second event.
- Round-robin: `d_in=4'b1111` rises at edge 5 → `evt_id` sequence 0,1,2,3 on consecutive cycles with no bubble. Then `4'b0000`, then `4'b0101` rises → sequence 0,2.
- Backpressure: `evt_ready=0`, `d_in[1]` rises → `evt_valid=1`, `evt_id=1` held stable for 20 cycles. A second rise on ch1 during that hold → no overflow and a second event after the handshake. A third rise before the handshake → `ovf=4'b0010`.
- Overflow clear: with `ovf[1]=1`, pulse `ovf_clr` → `ovf=0` next cycle. `ovf_clr` in the same cycle as a new overflow → bit stays 1.
- Enable mask: `ch_en[3]=0`, `d_in[3]` rises → no event. `ch_en[3]=1` while `d_in[3]` held high → no event until a new 0→1.
- Reset mid-offer: assert `rstn=0` while `evt_valid=1` with pending events → `evt_valid=0` and `ovf=0` immediately. After release with `d_in=0`, no events.
- Sync build: repeat the single-edge test with `EDGE_ARB_SYNC_EN` defined → event is visible after edge 13.
